// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the fetch/decode/execute core: load-use stalls,
// data-memory wait with timeout, and post-branch flush control.
module pipe_ctrl #(
    parameter int unsigned LEN_REGNO    = 4,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT  = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dec_valid,
    input  logic [LEN_REGNO-1:0] dec_rs_regno,
    input  logic [LEN_REGNO-1:0] dec_rd_regno,
    input  logic                 dec_reads_rd,
    input  logic                 ex_is_ld,
    input  logic [LEN_REGNO-1:0] ex_rd_regno,
    input  logic                 ex_mem_start,
    input  logic                 br_taken,
    input  logic                 mem_ack,
    output logic                 fetch_en,
    output logic                 dec_stall,
    output logic                 ex_bubble,
    output logic                 flush,
    output logic                 mem_req,
    output logic                 timeout_err,
    output logic [1:0]           state_o
);

    localparam int unsigned WAIT_W  = 8;
    localparam int unsigned FLUSH_W = 3;

    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_CYCLES - 1);
    localparam logic               MULTI_FLUSH = (FLUSH_CYCLES > 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_ERR      = 2'd3
    } state_e;

    state_e              state_q,       state_d;
    logic [WAIT_W-1:0]   wait_cnt_q,    wait_cnt_d;
    logic [FLUSH_W-1:0]  flush_cnt_q,   flush_cnt_d;
    logic                mem_req_q,     mem_req_d;
    logic                timeout_err_q, timeout_err_d;

    logic load_use;

    // Decode instruction needs the register the in-flight load has not yet written
    assign load_use = dec_valid && ex_is_ld &&
                      ((dec_rs_regno == ex_rd_regno) ||
                       (dec_reads_rd && (dec_rd_regno == ex_rd_regno)));

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        mem_req_d     = mem_req_q;
        timeout_err_d = timeout_err_q;
        fetch_en      = 1'b1;
        dec_stall     = 1'b0;
        ex_bubble     = 1'b0;
        flush         = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                // Memory start outranks a coincident branch; the branch is dropped
                if (ex_mem_start) begin
                    state_d    = ST_MEM_WAIT;
                    mem_req_d  = 1'b1;
                    wait_cnt_d = '0;
                end else if (br_taken) begin
                    flush = 1'b1;
                    if (MULTI_FLUSH) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_LOAD;
                    end
                end else if (load_use) begin
                    fetch_en  = 1'b0;
                    dec_stall = 1'b1;
                    ex_bubble = 1'b1;
                end
            end

            ST_MEM_WAIT: begin
                fetch_en  = 1'b0;
                dec_stall = 1'b1;
                // Ack is honoured even on the final allowed cycle
                if (mem_ack) begin
                    state_d   = ST_RUN;
                    mem_req_d = 1'b0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d       = ST_ERR;
                    mem_req_d     = 1'b0;
                    timeout_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            ST_FLUSH: begin
                flush       = 1'b1;
                ex_bubble   = 1'b1;
                flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
                if (flush_cnt_q == FLUSH_W'(1)) begin
                    state_d = ST_RUN;
                end
            end

            ST_ERR: begin
                fetch_en  = 1'b0;
                dec_stall = 1'b1;
                ex_bubble = 1'b1;
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            flush_cnt_q   <= '0;
            mem_req_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            mem_req_q     <= mem_req_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign timeout_err = timeout_err_q;
    assign state_o     = state_q;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline sequencer for the fetch → decode → execute core.
- Generates stall, bubble and flush controls for the instruction fetcher, decoder and execute stage.
- Detects load-use hazards, holds the pipe during multi-cycle data-memory accesses (req/ack handshake with timeout), and flushes wrong-path instructions after a taken branch.
- Sits in the top level beside the three stage blocks; it has no datapath of its own.

Parameters:
LEN_REGNO, 4, register-number width (matches the decoder rd/rs fields)
FLUSH_CYCLES, 2, cycles flush is held after a taken branch (legal range 1..7)
MEM_TIMEOUT, 15, MEM_WAIT cycles without ack before error (legal range 1..255)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
dec_valid  input  1  decode stage holds a valid instruction
dec_rs_regno  input  LEN_REGNO  source register of the decode-stage instruction
dec_rd_regno  input  LEN_REGNO  destination register of the decode-stage instruction
dec_reads_rd  input  1  decode-stage instruction also reads rd (two-operand ALU ops)
ex_is_ld  input  1  execute stage holds a load
ex_rd_regno  input  LEN_REGNO  destination register of the execute-stage instruction
ex_mem_start  input  1  execute stage begins a load/store this cycle
br_taken  input  1  execute stage resolved a taken branch this cycle
mem_ack  input  1  data memory completes the outstanding access
fetch_en  output  1  fetcher may advance PC / latch new instruction
dec_stall  output  1  decoder holds its outputs
ex_bubble  output  1  execute stage receives a NOP instead of the decode output
flush  output  1  squash instructions in fetch and decode
mem_req  output  1  outstanding data-memory request (registered)
timeout_err  output  1  sticky memory-timeout flag (registered)
state_o  output  2  current state, for debug

Behaviour:
- States:
  - RUN=0
  - MEM_WAIT=1
  - FLUSH=2
  - ERR=3
- Registers: state, wait_cnt (8b), flush_cnt (3b), mem_req, timeout_err.
- Reset (async, active-high): state=RUN, counters=0, mem_req=0, timeout_err=0.
  - Combinational outputs at reset: fetch_en=1, dec_stall=0, ex_bubble=0, flush=0.
  - Reset mid-access drops mem_req immediately. Memory must discard the request.
- RUN, priority highest first:
  - ex_mem_start: next state MEM_WAIT, mem_req←1, wait_cnt←0. Current cycle outputs are normal (fetch_en=1, no stall).
  - br_taken: flush=1 this cycle, fetch_en=1 (redirect). If FLUSH_CYCLES>1, next state FLUSH with flush_cnt←FLUSH_CYCLES-1; otherwise stay in RUN.
  - Load-use: dec_valid && ex_is_ld && (dec_rs_regno==ex_rd_regno || (dec_reads_rd && dec_rd_regno==ex_rd_regno)). Drive fetch_en=0, dec_stall=1, ex_bubble=1 for this cycle only; state stays RUN. The next cycle re-evaluates with the bubble in execute (ex_is_ld=0).
  - Otherwise: fetch_en=1, all other controls 0.
  - ex_mem_start together with br_taken is a protocol violation. Memory wins and the branch is ignored.
- MEM_WAIT:
  - Outputs: fetch_en=0, dec_stall=1, ex_bubble=0 (execute holds), mem_req=1.
  - mem_ack=1: next state RUN, mem_req←0. ack is accepted even in the cycle wait_cnt reaches the limit (ack beats timeout).
  - mem_ack=0: wait_cnt←wait_cnt+1. When wait_cnt==MEM_TIMEOUT-1 with no ack: next state ERR, timeout_err←1, mem_req←0.
  - br_taken and ex_mem_start are ignored in MEM_WAIT.
- FLUSH:
  - Outputs: flush=1, fetch_en=1, dec_stall=0, ex_bubble=1.
  - flush_cnt decrements each cycle; at flush_cnt==1, next state RUN.
  - All other inputs are ignored.
- ERR:
  - Outputs: fetch_en=0, dec_stall=1, ex_bubble=1, flush=0, mem_req=0, timeout_err=1.
  - Exit only by reset.
- mem_req and timeout_err are registered; all other control outputs are combinational from state and inputs.
- Register compares are full LEN_REGNO-bit equality. Register 0 is not special.

Test Plan:
- Reset release, dec_valid=1, no hazards → fetch_en=1, dec_stall=0, ex_bubble=0, flush=0, state_o=0, mem_req=0.
- ex_is_ld=1, ex_rd=3, dec_rs=3 → exactly one cycle of fetch_en=0/dec_stall=1/ex_bubble=1. Repeat with dec_rs=2, dec_rd=3: stall only when dec_reads_rd=1.
- ex_mem_start pulse, mem_ack on the 4th MEM_WAIT cycle → mem_req high for 4 cycles, fetch_en low for the same 4 cycles, then RUN.
- ex_mem_start, never ack, MEM_TIMEOUT=15 → ERR after 15 MEM_WAIT cycles: timeout_err=1 sticky, mem_req=0; async rst clears it mid-cycle.
- br_taken with FLUSH_CYCLES=2 → flush=1 for 2 cycles, ex_bubble=1 in the 2nd cycle. br_taken with a coincident load-use → flush only, no stall.
- mem_ack on the same cycle wait_cnt reaches the limit → returns to RUN, timeout_err stays 0. ex_mem_start with br_taken → MEM_WAIT entered, no flush.
